// File: rtl/result_display.sv
// Collects the 12 engine results (PE, 2x2, 3x3 x four positions) and scans them onto one display bus while done is high.
// Optional cross-engine compare behind `RESULT_CHECK_EN`; without it mismatch is tied low.
module result_display #(
  parameter int WIDTH = 8,
  parameter int DWELL = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             done,
  input  logic             pe_c00,
  input  logic             pe_c01,
  input  logic             pe_c10,
  input  logic             pe_c11,
  input  logic             sa2x2_c00,
  input  logic             sa2x2_c01,
  input  logic             sa2x2_c10,
  input  logic             sa2x2_c11,
  input  logic             sa3x3_c00,
  input  logic             sa3x3_c01,
  input  logic             sa3x3_c10,
  input  logic             sa3x3_c11,
  input  logic [WIDTH-1:0] pe_out,
  input  logic [WIDTH-1:0] sa2x2_out,
  input  logic [WIDTH-1:0] sa3x3_out,
  output logic [WIDTH-1:0] display_output,
  output logic [3:0]       display_idx,
  output logic             display_valid,
  output logic             all_captured,
  output logic             mismatch
);

  localparam logic [7:0] LP_DWELL_LAST = 8'(DWELL - 1);

  typedef enum logic {CAPTURE = 1'b0, SCAN = 1'b1} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_buf [12];
  logic [11:0]      r_bitmap;
  logic [7:0]       r_cnt;
  logic [11:0]      w_strobe;
  logic [WIDTH-1:0] w_wdat [12];

  // Slot order: engine-major, then position 00, 01, 10, 11.
  assign w_strobe = {sa3x3_c11, sa3x3_c10, sa3x3_c01, sa3x3_c00,
                     sa2x2_c11, sa2x2_c10, sa2x2_c01, sa2x2_c00,
                     pe_c11,    pe_c10,    pe_c01,    pe_c00};

  always_comb begin
    for (int i = 0; i < 12; i++) begin
      w_wdat[i] = (i < 4) ? pe_out : ((i < 8) ? sa2x2_out : sa3x3_out);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= CAPTURE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    if (clear) begin
      w_state_nxt = CAPTURE;
    end else begin
      case (r_state)
        CAPTURE: if (done)  w_state_nxt = SCAN;
        SCAN:    if (!done) w_state_nxt = CAPTURE;
        default:            w_state_nxt = CAPTURE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 12; i++) r_buf[i] <= '0;
      r_bitmap       <= '0;
      r_cnt          <= '0;
      display_idx    <= '0;
      display_output <= '0;
      display_valid  <= 1'b0;
      all_captured   <= 1'b0;
    end else if (clear) begin
      for (int i = 0; i < 12; i++) r_buf[i] <= '0;
      r_bitmap       <= '0;
      r_cnt          <= '0;
      display_idx    <= '0;
      display_output <= '0;
      display_valid  <= 1'b0;
      all_captured   <= 1'b0;
    end else begin
      for (int i = 0; i < 12; i++) begin
        if (w_strobe[i]) r_buf[i] <= w_wdat[i];
      end
      r_bitmap      <= r_bitmap | w_strobe;
      all_captured  <= &r_bitmap;
      display_valid <= (w_state_nxt == SCAN);
      if (r_state == CAPTURE && done) begin
        display_idx <= '0;
        r_cnt       <= '0;
      end else if (r_state == SCAN && done) begin
        if (r_cnt == LP_DWELL_LAST) begin
          r_cnt       <= '0;
          display_idx <= (display_idx == 4'd11) ? 4'd0 : display_idx + 4'd1;
        end else begin
          r_cnt <= r_cnt + 8'd1;
        end
      end
      // Reads the pre-write buffer, so a capture on the shown slot lands one cycle later.
      if (r_state == SCAN) display_output <= r_buf[display_idx];
    end
  end

`ifdef RESULT_CHECK_EN
  logic w_diff;
  logic r_mismatch;

  always_comb begin
    w_diff = 1'b0;
    for (int p = 0; p < 4; p++) begin
      if (r_bitmap[p] && r_bitmap[p+4] && r_bitmap[p+8] &&
          !(r_buf[p] == r_buf[p+4] && r_buf[p] == r_buf[p+8])) begin
        w_diff = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)        r_mismatch <= 1'b0;
    else if (clear) r_mismatch <= 1'b0;
    else            r_mismatch <= (w_state_nxt == SCAN) && w_diff;
  end

  assign mismatch = r_mismatch;
`else
  assign mismatch = 1'b0;
`endif

endmodule

// File: tb/tb_result_display.sv
// Directed self-checking bench for result_display (WIDTH=8, DWELL=4).
module tb_result_display;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       clear = 1'b0;
  logic       done = 1'b0;
  logic [11:0] strb = '0;
  logic [7:0] pe_out = '0;
  logic [7:0] sa2x2_out = '0;
  logic [7:0] sa3x3_out = '0;
  logic [7:0] display_output;
  logic [3:0] display_idx;
  logic       display_valid;
  logic       all_captured;
  logic       mismatch;

  logic [7:0] exp_buf [12];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  result_display #(.WIDTH(8), .DWELL(DW)) dut (
    .clk(clk), .rst(rst), .clear(clear), .done(done),
    .pe_c00(strb[0]), .pe_c01(strb[1]), .pe_c10(strb[2]), .pe_c11(strb[3]),
    .sa2x2_c00(strb[4]), .sa2x2_c01(strb[5]), .sa2x2_c10(strb[6]), .sa2x2_c11(strb[7]),
    .sa3x3_c00(strb[8]), .sa3x3_c01(strb[9]), .sa3x3_c10(strb[10]), .sa3x3_c11(strb[11]),
    .pe_out(pe_out), .sa2x2_out(sa2x2_out), .sa3x3_out(sa3x3_out),
    .display_output(display_output), .display_idx(display_idx),
    .display_valid(display_valid), .all_captured(all_captured), .mismatch(mismatch)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic write_slot(input int slot, input logic [7:0] v);
    strb = '0;
    strb[slot] = 1'b1;
    if (slot < 4)      pe_out = v;
    else if (slot < 8) sa2x2_out = v;
    else               sa3x3_out = v;
    exp_buf[slot] = v;
    step();
    strb = '0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;
    step();
    clear = 1'b0;
  endtask

  // Enter SCAN and compare idx/output against the model for ncyc cycles.
  task automatic run_scan(input int ncyc, input logic exp_all);
    done = 1'b1;
    step();
    chk("enter_valid", {31'd0, display_valid}, 32'd1);
    chk("enter_idx", {28'd0, display_idx}, 32'd0);
    for (int n = 1; n <= ncyc; n++) begin
      step();
      chk("scan_idx", {28'd0, display_idx}, (n / DW) % 12);
      chk("scan_out", {24'd0, display_output}, {24'd0, exp_buf[((n - 1) / DW) % 12]});
      chk("scan_valid", {31'd0, display_valid}, 32'd1);
    end
    chk("scan_allcap", {31'd0, all_captured}, {31'd0, exp_all});
  endtask

  task automatic stop_scan();
    done = 1'b0;
    step();
    chk("leave_valid", {31'd0, display_valid}, 32'd0);
  endtask

  initial begin
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;
    #12;
    chk("rst_out", {24'd0, display_output}, 32'd0);
    chk("rst_idx", {28'd0, display_idx}, 32'd0);
    chk("rst_valid", {31'd0, display_valid}, 32'd0);
    chk("rst_allcap", {31'd0, all_captured}, 32'd0);
    chk("rst_mismatch", {31'd0, mismatch}, 32'd0);
    rst = 1'b0;
    step();

    // Full capture 0x10+index, then scan with wrap.
    for (int i = 0; i < 12; i++) write_slot(i, 8'(8'h10 + i));
    step();
    chk("full_allcap", {31'd0, all_captured}, 32'd1);
    run_scan(12 * DW + 5, 1'b1);
`ifdef RESULT_CHECK_EN
    chk("full_mismatch", {31'd0, mismatch}, 32'd1);
`else
    chk("full_mismatch", {31'd0, mismatch}, 32'd0);
`endif
    stop_scan();
    chk("capture_valid_stays", {31'd0, display_valid}, 32'd0);

    do_clear();
    chk("clr_allcap", {31'd0, all_captured}, 32'd0);
    chk("clr_idx", {28'd0, display_idx}, 32'd0);
    chk("clr_out", {24'd0, display_output}, 32'd0);

    // Only PE position 00 written.
    write_slot(0, 8'h05);
    run_scan(12 * DW + 1, 1'b0);
    stop_scan();
    do_clear();

    // Two simultaneous 2x2 strobes share one bus value.
    strb = 12'b0000_1001_0000;
    sa2x2_out = 8'h3C;
    exp_buf[4] = 8'h3C;
    exp_buf[7] = 8'h3C;
    step();
    strb = '0;
    run_scan(8 * DW + 1, 1'b0);

    // Clear during SCAN beats a same-edge write to slot 1.
    clear = 1'b1;
    strb[1] = 1'b1;
    pe_out = 8'h7F;
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;
    step();
    clear = 1'b0;
    strb = '0;
    chk("clrscan_valid", {31'd0, display_valid}, 32'd0);
    chk("clrscan_idx", {28'd0, display_idx}, 32'd0);
    chk("clrscan_out", {24'd0, display_output}, 32'd0);
    chk("clrscan_allcap", {31'd0, all_captured}, 32'd0);
    chk("clrscan_mismatch", {31'd0, mismatch}, 32'd0);
    run_scan(2 * DW + 1, 1'b0);
    stop_scan();
    do_clear();

    // Position 10 disagreement between engines.
    write_slot(2, 8'h22);
    write_slot(6, 8'h22);
    write_slot(10, 8'h23);
    run_scan(DW + 2, 1'b0);
`ifdef RESULT_CHECK_EN
    chk("mm_high", {31'd0, mismatch}, 32'd1);
`else
    chk("mm_high", {31'd0, mismatch}, 32'd0);
`endif
    stop_scan();
    chk("mm_capture", {31'd0, mismatch}, 32'd0);
    write_slot(10, 8'h22);
    run_scan(DW + 2, 1'b0);
    chk("mm_low", {31'd0, mismatch}, 32'd0);

    // Asynchronous reset mid-scan (idx is nonzero here).
    #2;
    rst = 1'b1;
    #1;
    chk("arst_out", {24'd0, display_output}, 32'd0);
    chk("arst_idx", {28'd0, display_idx}, 32'd0);
    chk("arst_valid", {31'd0, display_valid}, 32'd0);
    done = 1'b0;
    #2;
    rst = 1'b0;
    for (int i = 0; i < 12; i++) exp_buf[i] = 8'h00;
    step();
    chk("post_rst_valid", {31'd0, display_valid}, 32'd0);
    chk("post_rst_idx", {28'd0, display_idx}, 32'd0);
    run_scan(DW + 1, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/result_display.md
# result_display

Downstream collector for the three convolution engines (single PE, 2x2 and 3x3 systolic arrays). It latches each engine's 8-bit result into a 12-entry buffer, one entry per engine and output position, under the controller's per-position capture strobes. Once the controller raises `done`, it scans the buffer onto a single 8-bit display bus, holding each entry for a programmable dwell time.

## Interface
- `WIDTH`, 8: result and display data width.
- `DWELL`, 4: cycles each entry is held in SCAN; legal range 1..255.

Ports:
- `clk` in 1: system clock; all state updates on the rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `clear` in 1: synchronous buffer/state clear, used at the start of a new run.
- `done` in 1: level signal from the controller; results complete.
- `pe_c00`, `pe_c01`, `pe_c10`, `pe_c11` in 1 each: single-PE capture strobes for result positions 00/01/10/11.
- `sa2x2_c00` .. `sa2x2_c11` in 1 each: 2x2 array capture strobes.
- `sa3x3_c00` .. `sa3x3_c11` in 1 each: 3x3 array capture strobes.
- `pe_out`, `sa2x2_out`, `sa3x3_out` in WIDTH: engine result buses.
- `display_output` out WIDTH: currently displayed result.
- `display_idx` out 4: buffer index being shown; 0-3 PE, 4-7 2x2, 8-11 3x3; position order 00, 01, 10, 11.
- `display_valid` out 1: high while in SCAN.
- `all_captured` out 1: all 12 entries written since the last reset or clear.
- `mismatch` out 1: cross-engine disagreement flag.

## Operation
- Buffer: 12 x WIDTH registers plus a 12-bit written bitmap.
- Writes:
  - On each edge, every asserted strobe writes its engine's `*_out` into its slot and sets the slot's bitmap bit.
  - Multiple simultaneous strobes are legal; each addressed slot receives the same bus value.
  - Writes are accepted in both states.
- FSM states: CAPTURE (reset state) and SCAN.
  - CAPTURE -> SCAN: when `done` is sampled high. On that edge `display_idx` <= 0 and the dwell counter <= 0.
  - SCAN -> CAPTURE: when `done` is sampled low.
  - Any state -> CAPTURE: `clear` high.
- SCAN sequencing:
  - The dwell counter increments each cycle.
  - When it reaches DWELL-1, it resets to 0 and `display_idx` advances.
  - After 11, `display_idx` wraps to 0; scanning repeats while `done` stays high.
- `clear`:
  - Zeroes all buffer entries and the bitmap, forces CAPTURE, and zeroes `display_idx` and `display_output`.
  - Has priority over strobes written on the same edge: those writes are dropped.
- Unwritten slots read as 0.
- `all_captured` = AND of the bitmap, registered.
- Reset values: all outputs 0; buffer and bitmap 0; state CAPTURE.

## Timing
- `display_output` is registered from `buf[display_idx]` every cycle in SCAN, so it lags `display_idx` by one cycle.
- The first valid data appears 2 edges after `done` is first sampled high.
- In CAPTURE, `display_output` holds its last value; `display_valid` = 0.
- `display_valid` is registered: high from the edge that enters SCAN, low from the edge that leaves it.
- A capture landing on the slot currently shown appears on `display_output` the following cycle.
- With `DWELL`=1, `display_idx` advances every cycle.
- Asserting `rst` mid-scan returns all outputs to 0 immediately (asynchronous).

## Configuration
- `RESULT_CHECK_EN` defined:
  - `mismatch` is registered each cycle.
  - It is high in SCAN if, for any position p whose three slots (PE, 2x2, 3x3) are all written, the three values are not all equal.
  - It is 0 in CAPTURE and after reset or clear.
- `RESULT_CHECK_EN` undefined:
  - `mismatch` is tied to 0.
  - No comparison logic is built.
  - The port remains present.

## Test plan
- Reset, then strobe each of the 12 positions once with value 0x10+index, then raise `done` with `DWELL`=4:
  - `display_idx` steps 0..11, then wraps to 0.
  - `display_output` = 0x10..0x1B, each held for 4 cycles, lagging `display_idx` by one cycle.
  - `all_captured` = 1.
- Write only `pe_c00`=0x05, then raise `done`: index 0 shows 0x05, all other indices show 0x00, and `all_captured` = 0.
- Assert `sa2x2_c00` and `sa2x2_c11` together with `sa2x2_out`=0x3C: slots 4 and 7 both read 0x3C.
- During SCAN, pulse `clear` on the same edge as `pe_c01` with 0x7F: state returns to CAPTURE, slot 1 reads 0, and all outputs are 0.
- With `RESULT_CHECK_EN` defined:
  - PE, 2x2 and 3x3 position 10 = 0x22, 0x22, 0x23, with `done` high: `mismatch` = 1.
  - Set 0x23 to 0x22 and rescan: `mismatch` = 0.
  - Without the macro, `mismatch` stays 0.
- Assert `rst` asynchronously mid-SCAN: outputs go to 0 before the next edge, and the FSM resumes in CAPTURE after release.
